huff_bit_packer: RTL and testbench
==================================

Name: huff_bit_packer

Overview:
- Downstream stage of the Huffman encoder.
- Captures the codebook the encoder streams on its 9-bit output (a character beat followed by a mask/value beat, per symbol).
- Then accepts a stream of 5-bit symbols, replaces each with its variable-length code, and packs the codes MSB-first into bytes on a valid/ready output.
- On the last symbol it zero-pads to a byte boundary and flags the final byte.

Parameters:
- MAX_CHAR_COUNT, 3, number of codebook entries to capture (must match the encoder).
- CODE_W, 3, maximum code length in bits (equals the encoder mask/value width).
- ACC_W, 16, bit-accumulator width; must be at least 8+CODE_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cb_in  in  9  codebook beat from the encoder; [8]=done
  - char beat: [7:5]=3'b011, [4:0]=char
  - code beat: [7:6]=0, [5:3]=mask, [2:0]=value
- sym_valid  in  1  symbol present
- sym_char  in  5  symbol to encode
- sym_last  in  1  marks the final symbol of a message
- sym_ready  out  1  symbol accepted when sym_valid&&sym_ready
- out_valid  out  1  out_byte valid
- out_byte  out  8  packed bits; first code bit is at [7]
- out_last  out  1  final (padded) byte of the message
- out_ready  in  1  downstream accepts the byte
- cb_loaded  out  1  codebook captured; encoding enabled
- sym_err  out  1  one-cycle pulse when an accepted symbol matches no codebook entry

Behaviour:
- Reset values:
  - All outputs 0; state=CB_LOAD.
  - Codebook, accumulator and bit count (cnt) cleared.
  - Applies mid-operation too: a partial byte is discarded and the codebook must be reloaded.
- CB_LOAD:
  - Ignore cb_in while cb_in[8]=0.
  - Each cycle with cb_in[8]=1 is one beat. Beat index k counts 0..2*MAX_CHAR_COUNT-1.
  - Even k: require [7:5]=3'b011 and store char[k/2]. On a tag mismatch, reset k to 0 and keep waiting.
  - Odd k: store mask[k/2] and value[k/2].
  - Code length of an entry = popcount(mask).
  - After the last beat: go to CB_DRAIN.
- CB_DRAIN:
  - Wait until cb_in[8]=0; this discards the encoder's extra trailing beats.
  - Then set cb_loaded=1 and go to ENCODE.
- ENCODE:
  - sym_ready = (cnt <= ACC_W-CODE_W), combinational from registered cnt.
  - On acceptance:
    - Look up sym_char against the stored chars.
    - On a hit, append the len code bits value[len-1:0] MSB-first below the cnt valid bits; cnt += len.
    - On a miss, pulse sym_err the next cycle and append nothing.
    - If sym_last=1, go to FLUSH after the append. sym_ready=0 in FLUSH.
- Output (all states after CB_LOAD):
  - out_valid=1 when cnt>=8, or when in FLUSH with cnt>0.
  - out_byte = top 8 valid bits; in FLUSH with cnt<8, the low bits are 0-padded.
  - A byte is popped on out_valid&&out_ready: the accumulator shifts left 8 and cnt -= min(8,cnt).
  - Pop and symbol append in the same cycle are allowed; cnt' = cnt - popped + len.
  - out_byte and out_valid must hold stable while out_valid&&!out_ready.
- FLUSH:
  - out_last=1 with the byte that brings cnt to 0.
  - If cnt is already 0 on entry (message of only unknown symbols), emit no byte.
  - After the last pop, return to ENCODE with the codebook retained.
- Codebook reload:
  - Assert reset. No other reload path.
- Latency:
  - An accepted symbol whose bits complete a byte gives out_valid on the next cycle.

Optional Feature:
- HUFF_PACK_BITCOUNT_EN.
- Defined:
  - Adds output msg_bits (16 bits): unpadded code bits of the current message.
  - Cleared on reset and on the cycle after the out_last pop.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent.

Decomposition:
- Shared package huff_pkg:
  - MAX_CHAR_COUNT and CODE_W constants.
  - Beat tag constant 3'b011.
  - Typedef cb_entry_t {char[4:0], mask[CODE_W-1:0], value[CODE_W-1:0], len}.
  - State enum.
- One sub-module: huff_cb_lookup. Combinational; takes the codebook array and sym_char, returns hit, code and len.

Test Plan:
- Codebook load and encode:
  - Beats: {1,011,01}, {1,00,011,000}, {1,011,02}, {1,00,011,001}, {1,011,03}, {1,00,001,001}, plus 2 extra done beats.
  - Response: cb_loaded=1 only after cb_in[8] falls.
  - Then symbols 03,01,02,03,03,01 (last on the final one) -> out_byte 8'h8E, then 8'h00 with out_last=1.
- Backpressure:
  - Same codebook; hold out_ready=0 while sending 20 symbols of 02.
  - Response: sym_ready drops when cnt>13; out_byte stays constant.
  - Releasing out_ready gives bytes of 8'h55 pattern in order, with no bits lost.
- Unknown symbol:
  - Send 07 between 03 and 03 (last).
  - Response: sym_err pulses once; output is 8'hC0 with out_last.
- Exact byte boundary:
  - Eight 03 symbols, last on the 8th.
  - Response: a single 8'hFF with out_last=1; no padding byte.
- Reset mid-message:
  - Assert reset with cnt=5.
  - Response: all outputs 0; cb_loaded=0; no byte emitted afterwards until a new codebook load.
- HUFF_PACK_BITCOUNT_EN:
  - Run scenario 1.
  - Response: msg_bits=9 before the out_last pop, then 0.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared constants, codebook entry type and FSM states for the Huffman bit packer.
package huff_pkg;

    localparam int MAX_CHAR_COUNT = 3;
    localparam int CODE_W         = 3;
    localparam int LEN_W          = $clog2(CODE_W + 1);
    localparam int BEAT_W         = $clog2(2 * MAX_CHAR_COUNT);
    localparam int IDX_W          = BEAT_W - 1;

    localparam logic [2:0] CHAR_TAG = 3'b011;

    typedef struct packed {
        logic [4:0]        chr;
        logic [CODE_W-1:0] mask;
        logic [CODE_W-1:0] value;
        logic [LEN_W-1:0]  len;
    } cb_entry_t;

    typedef enum logic [1:0] {
        CB_LOAD,
        CB_DRAIN,
        ENCODE,
        FLUSH
    } state_t;

    function automatic logic [LEN_W-1:0] popCount(input logic [CODE_W-1:0] m);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + LEN_W'(m[i]);
        end
        return n;
    endfunction

    function automatic logic [CODE_W-1:0] lowMask(input logic [LEN_W-1:0] len);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/huff_cb_lookup.sv
// Combinational codebook search: maps a symbol to its code bits and length.
module huff_cb_lookup
    import huff_pkg::*;
(
    input  cb_entry_t [MAX_CHAR_COUNT-1:0] i_cb,
    input  logic [4:0]                     i_sym,
    output logic                           o_hit,
    output logic [CODE_W-1:0]              o_code,
    output logic [LEN_W-1:0]               o_len
);

    // Scan from the top so the lowest matching index wins on duplicate chars.
    always_comb begin
        o_hit  = 1'b0;
        o_code = '0;
        o_len  = '0;
        for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
            if (i_cb[i].chr == i_sym) begin
                o_hit  = 1'b1;
                o_code = i_cb[i].value & i_cb[i].mask & lowMask(i_cb[i].len);
                o_len  = i_cb[i].len;
            end
        end
    end

endmodule

// File: rtl/huff_bit_packer.sv
// Captures the encoder codebook, then packs variable-length codes MSB-first into bytes.
// Optional HUFF_PACK_BITCOUNT_EN adds the msg_bits per-message code bit counter.
module huff_bit_packer
    import huff_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] cb_in,
    input  logic       sym_valid,
    input  logic [4:0] sym_char,
    input  logic       sym_last,
    output logic       sym_ready,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_last,
    input  logic       out_ready,
    output logic       cb_loaded,
    output logic       sym_err
`ifdef HUFF_PACK_BITCOUNT_EN
    ,
    output logic [15:0] msg_bits
`endif
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] ACC_W_C = CNT_W'(ACC_W);
    localparam logic [CNT_W-1:0] BYTE_C  = CNT_W'(8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * MAX_CHAR_COUNT - 1);

    state_t                         r_state, w_nextState;
    cb_entry_t [MAX_CHAR_COUNT-1:0] r_cb;
    logic [BEAT_W-1:0]              r_beat;
    logic [ACC_W-1:0]               r_acc;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_symErr;

    logic              w_hit;
    logic [CODE_W-1:0] w_code;
    logic [LEN_W-1:0]  w_len;
    logic              w_accept, w_pop, w_append;
    logic [IDX_W-1:0]  w_idx;
    logic [CNT_W-1:0]  w_popAmt, w_base, w_addLen, w_shift, w_cntNext;
    logic [ACC_W-1:0]  w_ins, w_accNext;

    huff_cb_lookup u_lookup (
        .i_cb   (r_cb),
        .i_sym  (sym_char),
        .o_hit  (w_hit),
        .o_code (w_code),
        .o_len  (w_len)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= CB_LOAD;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        sym_ready   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        cb_loaded   = 1'b0;
        case (r_state)
            CB_LOAD: begin
                if (cb_in[8] && r_beat == LAST_BEAT) w_nextState = CB_DRAIN;
            end
            CB_DRAIN: begin
                if (!cb_in[8]) w_nextState = ENCODE;
            end
            ENCODE: begin
                cb_loaded = 1'b1;
                sym_ready = (r_cnt <= CNT_W'(ACC_W - CODE_W));
                out_valid = (r_cnt >= BYTE_C);
                if (sym_valid && sym_ready && sym_last) w_nextState = FLUSH;
            end
            FLUSH: begin
                cb_loaded = 1'b1;
                out_valid = (r_cnt != '0);
                out_last  = out_valid && (r_cnt <= BYTE_C);
                if (r_cnt == '0 || (out_last && out_ready)) w_nextState = ENCODE;
            end
            default: w_nextState = CB_LOAD;
        endcase
    end

    assign w_accept = sym_valid && sym_ready;
    assign w_pop    = out_valid && out_ready;
    assign w_append = w_accept && w_hit;
    assign w_idx    = r_beat[BEAT_W-1:1];
    assign out_byte = r_acc[ACC_W-1 -: 8];
    assign sym_err  = r_symErr;

    // New code bits land just below the bits that survive this cycle's pop.
    always_comb begin
        w_popAmt  = '0;
        if (w_pop) w_popAmt = (r_cnt >= BYTE_C) ? BYTE_C : r_cnt;
        w_base    = r_cnt - w_popAmt;
        w_addLen  = w_append ? CNT_W'(w_len) : '0;
        w_shift   = ACC_W_C - w_base - CNT_W'(w_len);
        w_ins     = ACC_W'(w_code) << w_shift;
        w_cntNext = w_base + w_addLen;
        w_accNext = (w_pop ? (r_acc << 8) : r_acc) | (w_append ? w_ins : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cb     <= '0;
            r_beat   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_symErr <= 1'b0;
        end else begin
            r_symErr <= w_accept && !w_hit;
            r_acc    <= w_accNext;
            r_cnt    <= w_cntNext;
            if (r_state == CB_LOAD && cb_in[8]) begin
                if (!r_beat[0]) begin
                    if (cb_in[7:5] == CHAR_TAG) begin
                        r_cb[w_idx].chr <= cb_in[4:0];
                        r_beat          <= r_beat + 1'b1;
                    end else begin
                        r_beat <= '0;
                    end
                end else begin
                    r_cb[w_idx].mask  <= cb_in[2*CODE_W-1:CODE_W];
                    r_cb[w_idx].value <= cb_in[CODE_W-1:0];
                    r_cb[w_idx].len   <= popCount(cb_in[2*CODE_W-1:CODE_W]);
                    r_beat            <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
                end
            end
        end
    end

`ifdef HUFF_PACK_BITCOUNT_EN
    logic [15:0] r_msgBits;
    logic [16:0] w_bitSum;

    assign w_bitSum = {1'b0, r_msgBits} + 17'(w_addLen);
    assign msg_bits = r_msgBits;

    always_ff @(posedge clk) begin
        if (reset)                r_msgBits <= '0;
        else if (w_pop && out_last) r_msgBits <= '0;
        else if (w_bitSum[16])    r_msgBits <= 16'hFFFF;
        else                      r_msgBits <= w_bitSum[15:0];
    end
`else
    // No per-message bit counter in this build.
`endif

endmodule

// File: tb/tb_huff_bit_packer.sv
// Scoreboard bench for huff_bit_packer: directed symbol streams with hand-computed bytes.
module tb_huff_bit_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] cb_in;
    logic       sym_valid;
    logic [4:0] sym_char;
    logic       sym_last;
    logic       sym_ready;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_last;
    logic       out_ready;
    logic       cb_loaded;
    logic       sym_err;
`ifdef HUFF_PACK_BITCOUNT_EN
    logic [15:0] msg_bits;
`endif

    always #5 clk = ~clk;

    huff_bit_packer dut (
        .clk       (clk),
        .reset     (reset),
        .cb_in     (cb_in),
        .sym_valid (sym_valid),
        .sym_char  (sym_char),
        .sym_last  (sym_last),
        .sym_ready (sym_ready),
        .out_valid (out_valid),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .out_ready (out_ready),
        .cb_loaded (cb_loaded),
        .sym_err   (sym_err)
`ifdef HUFF_PACK_BITCOUNT_EN
        ,
        .msg_bits  (msg_bits)
`endif
    );

    typedef struct packed {
        logic [7:0]  b;
        logic        l;
        logic [15:0] bits;
    } exp_t;

    exp_t       sbQ[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         errPulses  = 0;
    logic       prevStall  = 1'b0;
    logic [7:0] prevByte   = 8'h00;

    // Bogus tag first (must be ignored), three entries, then two trailing done beats.
    logic [8:0] cbBeats [0:8] = '{9'h105, 9'h161, 9'h118, 9'h162, 9'h119,
                                  9'h163, 9'h109, 9'h1FF, 9'h100};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [7:0] b, input logic l, input logic [15:0] bits);
        exp_t e;
        e.b    = b;
        e.l    = l;
        e.bits = bits;
        sbQ.push_back(e);
    endtask

    // Present one symbol and hold it until accepted.
    task automatic applyStimulus(input logic [4:0] ch, input logic last);
        logic ok;
        ok        = 1'b0;
        sym_valid = 1'b1;
        sym_char  = ch;
        sym_last  = last;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = sym_ready;
            tick();
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL sym_accept: got no sym_ready, expected acceptance of 0x%0h", ch);
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic loadCodebook();
        for (int i = 0; i < 9; i++) begin
            cb_in = cbBeats[i];
            tick();
        end
        checkOutput("cb_loaded_while_done", cb_loaded, 0);
        cb_in = 9'h000;
        tick();
        checkOutput("cb_loaded_after_done", cb_loaded, 1);
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 300 && (sbQ.size() != 0 || out_valid); n++) tick();
        if (sbQ.size() != 0 || out_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending bytes, expected 0", sbQ.size());
        end
        tick();
        tick();
    endtask

    task automatic scenarioBasic();
        pushExp(8'h8E, 1'b0, 16'd0);
        pushExp(8'h00, 1'b1, 16'd9);
        applyStimulus(5'h03, 1'b0);
        applyStimulus(5'h01, 1'b0);
        applyStimulus(5'h02, 1'b0);
        applyStimulus(5'h03, 1'b0);
        applyStimulus(5'h03, 1'b0);
        applyStimulus(5'h01, 1'b1);
        waitIdle();
`ifdef HUFF_PACK_BITCOUNT_EN
        checkOutput("msg_bits_cleared", msg_bits, 0);
`endif
    endtask

    // Scoreboard monitor plus hold-stability check on a stalled byte.
    always @(negedge clk) begin
        exp_t e;
        if (sym_err) errPulses++;
        if (prevStall && out_valid) checkOutput("hold_byte", out_byte, prevByte);
        prevStall = out_valid && !out_ready;
        prevByte  = out_byte;
        if (out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h last=%0b, expected none", out_byte, out_last);
            end else begin
                e = sbQ.pop_front();
                checkOutput("out_byte", out_byte, e.b);
                checkOutput("out_last", out_last, e.l);
`ifdef HUFF_PACK_BITCOUNT_EN
                if (e.l) checkOutput("msg_bits_at_last", msg_bits, e.bits);
`endif
            end
        end
    end

    initial begin
        reset     = 1'b1;
        cb_in     = 9'h000;
        sym_valid = 1'b0;
        sym_char  = 5'h00;
        sym_last  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_byte", out_byte, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_sym_ready", sym_ready, 0);
        checkOutput("rst_cb_loaded", cb_loaded, 0);
        checkOutput("rst_sym_err", sym_err, 0);
        reset = 1'b0;
        tick();

        $display("[TB] codebook load and basic encode");
        loadCodebook();
        scenarioBasic();

        $display("[TB] unknown symbol");
        errPulses = 0;
        pushExp(8'hC0, 1'b1, 16'd2);
        applyStimulus(5'h03, 1'b0);
        applyStimulus(5'h07, 1'b0);
        applyStimulus(5'h03, 1'b1);
        waitIdle();
        checkOutput("sym_err_pulses", errPulses, 1);

        $display("[TB] exact byte boundary");
        pushExp(8'hFF, 1'b1, 16'd8);
        for (int i = 0; i < 8; i++) applyStimulus(5'h03, i == 7);
        waitIdle();

        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) pushExp(8'h55, 1'b0, 16'd0);
        pushExp(8'h55, 1'b1, 16'd40);
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus(5'h02, 1'b0);
        checkOutput("bp_sym_ready_low", sym_ready, 0);
        repeat (5) tick();
        checkOutput("bp_out_valid", out_valid, 1);
        checkOutput("bp_out_byte", out_byte, 8'h55);
        checkOutput("bp_sym_ready_still_low", sym_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) applyStimulus(5'h02, i == 12);
        waitIdle();

        $display("[TB] reset mid-message");
        applyStimulus(5'h03, 1'b0);
        applyStimulus(5'h01, 1'b0);
        applyStimulus(5'h01, 1'b0);
        checkOutput("mid_out_valid_cnt5", out_valid, 0);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_byte", out_byte, 0);
        checkOutput("mid_rst_cb_loaded", cb_loaded, 0);
        checkOutput("mid_rst_sym_ready", sym_ready, 0);
        reset     = 1'b0;
        sym_valid = 1'b1;
        sym_char  = 5'h03;
        sym_last  = 1'b1;
        repeat (10) begin
            tick();
            checkOutput("post_rst_no_byte", out_valid, 0);
        end
        checkOutput("post_rst_sym_ready", sym_ready, 0);
        checkOutput("post_rst_cb_loaded", cb_loaded, 0);
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        loadCodebook();
        scenarioBasic();

        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
